ram_op_ctrl: RTL and testbench

- Sequencer that owns the port of the 32x32 operand RAM and runs one arithmetic job per start pulse.
- Each job reads two operands from the selected region, computes subtract or add, and writes the result back.
- It then writes a status word to that operation's status slot.
- It sits between the top-level control and the RAM. Its outputs drive DirRam/DatosE/WE directly and DatosS is fed back as its read input.

---
 rtl/ram_op_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_op_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_op_ctrl.sv
`timescale 1ns/1ps
// Sequencer owning the operand RAM port: reads two operands, adds or subtracts,
// writes the result and a status word back using a set/pulse/hold write handshake.
module ram_op_ctrl #(
  parameter int unsigned RESTA_BASE = 0,
  parameter int unsigned SUMA_BASE  = 3,
  parameter int unsigned STAT_RESTA = 6,
  parameter int unsigned STAT_SUMA  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic [7:0]  job_cnt,
  output logic [4:0]  DirRam,
  output logic [31:0] DatosE,
  output logic        WE,
  input  logic [31:0] DatosS
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] RESTA_ADDR = AW'(RESTA_BASE);
  localparam logic [AW-1:0] SUMA_ADDR  = AW'(SUMA_BASE);
  localparam logic [AW-1:0] SRESTA_ADDR = AW'(STAT_RESTA);
  localparam logic [AW-1:0] SSUMA_ADDR  = AW'(STAT_SUMA);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CALC,
    S_W1_SET,
    S_W1_PUL,
    S_W1_HLD,
    S_W2_SET,
    S_W2_PUL,
    S_W2_HLD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic          op_q;
  logic [DW-1:0] op_a, op_b;

  logic          op_sel;
  logic [AW-1:0] base_addr, stat_addr;

  logic [DW:0]   sum_w, dif_w, calc_w;
  logic [DW-1:0] calc_r;
  logic          calc_cb, calc_ovf, calc_zero;
  logic [DW-1:0] stat_word;

  logic [AW-1:0] dir_d;
  logic [DW-1:0] datos_d;
  logic          we_d;

  // In IDLE the op being latched this edge must already steer the first read address.
  always_comb begin
    op_sel    = (state == S_IDLE) ? op : op_q;
    base_addr = op_sel ? SUMA_ADDR : RESTA_ADDR;
    stat_addr = op_sel ? SSUMA_ADDR : SRESTA_ADDR;
  end

  // Arithmetic: bit 32 is carry for add and borrow for subtract.
  always_comb begin
    sum_w     = {1'b0, op_a} + {1'b0, op_b};
    dif_w     = {1'b0, op_a} - {1'b0, op_b};
    calc_w    = op_q ? sum_w : dif_w;
    calc_r    = calc_w[DW-1:0];
    calc_cb   = calc_w[DW];
    calc_zero = (calc_r == '0);
    if (op_q) calc_ovf = (op_a[DW-1] == op_b[DW-1]) && (calc_r[DW-1] != op_a[DW-1]);
    else      calc_ovf = (op_a[DW-1] != op_b[DW-1]) && (calc_r[DW-1] != op_a[DW-1]);
    stat_word = {29'b0, calc_ovf, calc_zero, calc_cb};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next state, then RAM-side values for the state being entered.
  always_comb begin
    next_state = state;
    dir_d      = '0;
    datos_d    = '0;
    we_d       = 1'b0;

    case (state)
      S_IDLE:   if (start) next_state = S_RD_A;
      S_RD_A:   next_state = S_RD_B;
      S_RD_B:   next_state = S_CALC;
      S_CALC:   next_state = S_W1_SET;
      S_W1_SET: next_state = S_W1_PUL;
      S_W1_PUL: next_state = S_W1_HLD;
      S_W1_HLD: next_state = S_W2_SET;
      S_W2_SET: next_state = S_W2_PUL;
      S_W2_PUL: next_state = S_W2_HLD;
      S_W2_HLD: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase

    case (next_state)
      S_RD_A: dir_d = base_addr;
      S_RD_B: dir_d = base_addr + AW'(1);
      S_W1_SET, S_W1_PUL, S_W1_HLD: begin
        dir_d   = base_addr + AW'(2);
        datos_d = calc_r;
        we_d    = (next_state == S_W1_PUL);
      end
      S_W2_SET, S_W2_PUL, S_W2_HLD: begin
        dir_d   = stat_addr;
        datos_d = stat_word;
        we_d    = (next_state == S_W2_PUL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      DirRam  <= '0;
      DatosE  <= '0;
      WE      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flags   <= '0;
      job_cnt <= '0;
      op_q    <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      DirRam <= dir_d;
      DatosE <= datos_d;
      WE     <= we_d;
      busy   <= (next_state != S_IDLE);
      done   <= (next_state == S_DONE);
      if (state == S_IDLE && start) op_q <= op;
      if (state == S_RD_A) op_a <= DatosS;
      if (state == S_RD_B) op_b <= DatosS;
      if (state == S_CALC) begin
        result <= calc_r;
        flags  <= {calc_ovf, calc_zero, calc_cb};
      end
      if (next_state == S_DONE) job_cnt <= job_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ram_op_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ram_op_ctrl with a behavioural 32x32 RAM and a write-handshake monitor.
module tb_ram_op_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, op;
  logic        busy, done, WE;
  logic [31:0] result, DatosE, DatosS;
  logic [2:0]  flags;
  logic [7:0]  job_cnt;
  logic [4:0]  DirRam;

  logic [31:0] mem [32];

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_cnt = 8'd0;

  ram_op_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .busy(busy), .done(done), .result(result), .flags(flags), .job_cnt(job_cnt),
    .DirRam(DirRam), .DatosE(DatosE), .WE(WE), .DatosS(DatosS)
  );

  always #5 clk = ~clk;

  assign DatosS = mem[DirRam];

  always @(posedge clk) begin
    if (WE === 1'b1) mem[DirRam] = DatosE;
  end

  // Handshake monitor: a three-sample window centred on each WE-high cycle.
  logic [4:0]  a0, a1, a2;
  logic [31:0] d0, d1, d2;
  logic        w0, w1, w2, r2;
  int          hs_fail = 0;
  int          hs_seen = 0;
  int          we_total = 0;

  always @(negedge clk) begin
    a0 = a1; d0 = d1; w0 = w1;
    a1 = a2; d1 = d2; w1 = w2;
    a2 = DirRam; d2 = DatosE; w2 = WE; r2 = !rst_n;
    if (WE === 1'b1) we_total++;
    if (busy === 1'b0 && WE !== 1'b0) begin
      hs_fail++;
      $display("FAIL we_idle: WE=%b while busy=0 at %0t", WE, $time);
    end
    if (w1 === 1'b1 && r2 !== 1'b1) begin
      hs_seen++;
      if (a0 !== a1 || a2 !== a1 || d0 !== d1 || d2 !== d1 || w0 !== 1'b0 || w2 !== 1'b0) begin
        hs_fail++;
        $display("FAIL handshake: addr %h/%h/%h data %h/%h/%h we %b%b%b at %0t",
                 a0, a1, a2, d0, d1, d2, w0, w1, w2, $time);
      end
    end
  end

  // Pulse start for one sampled edge, then wait (bounded) for done; lat counts cycles from 1.
  task automatic run_job(input logic o, output int lat);
    @(posedge clk); #1; start = 1'b1; op = o;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (done === 1'b1) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, WE} !== 3'b000) $display("FAIL reset_ctl: busy/done/WE=%b want 000", {busy, done, WE}); else passed++;
    checks++; if (DirRam !== 5'd0 || DatosE !== 32'd0) $display("FAIL reset_ram: DirRam=%h DatosE=%h want 0/0", DirRam, DatosE); else passed++;
    checks++; if (result !== 32'd0 || flags !== 3'd0 || job_cnt !== 8'd0) $display("FAIL reset_regs: result=%h flags=%b job_cnt=%0d want 0", result, flags, job_cnt); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_suma();
    int lat, p0;
    mem[3] = 32'h0000_0005; mem[4] = 32'h0000_0007;
    mem[5] = 32'hDEAD_BEEF; mem[7] = 32'hFFFF_FFFF;
    p0 = we_total;
    run_job(1'b1, lat);
    checks++; if (lat !== 10) $display("FAIL suma_latency: done in cycle %0d want 10", lat); else passed++;
    checks++; if (result !== 32'h0000_000C) $display("FAIL suma_result: got %h want 0000000c", result); else passed++;
    checks++; if (flags !== 3'b000) $display("FAIL suma_flags: got %b want 000", flags); else passed++;
    checks++; if (mem[5] !== 32'h0000_000C || mem[7] !== 32'h0) $display("FAIL suma_mem: mem5=%h mem7=%h want 0000000c/0", mem[5], mem[7]); else passed++;
    checks++; if (job_cnt !== exp_cnt) $display("FAIL suma_jobcnt: got %0d want %0d", job_cnt, exp_cnt); else passed++;
    checks++; if (we_total - p0 !== 2) $display("FAIL suma_we_pulses: got %0d want 2", we_total - p0); else passed++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL suma_after: busy=%b done=%b want 0/0", busy, done); else passed++;
    checks++; if (result !== 32'h0000_000C) $display("FAIL suma_hold: result=%h want 0000000c", result); else passed++;
  endtask

  task automatic test_resta_borrow();
    int lat;
    mem[0] = 32'd3; mem[1] = 32'd5; mem[2] = 32'd0; mem[6] = 32'd0;
    run_job(1'b0, lat);
    checks++; if (lat !== 10) $display("FAIL resta_latency: done in cycle %0d want 10", lat); else passed++;
    checks++; if (result !== 32'hFFFF_FFFE || flags !== 3'b001) $display("FAIL resta_calc: result=%h flags=%b want fffffffe/001", result, flags); else passed++;
    checks++; if (mem[2] !== 32'hFFFF_FFFE || mem[6] !== 32'h1) $display("FAIL resta_mem: mem2=%h mem6=%h want fffffffe/1", mem[2], mem[6]); else passed++;
    checks++; if (job_cnt !== exp_cnt) $display("FAIL resta_jobcnt: got %0d want %0d", job_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_ovf_zero();
    int lat;
    mem[3] = 32'h7FFF_FFFF; mem[4] = 32'h1;
    run_job(1'b1, lat);
    checks++; if (result !== 32'h8000_0000 || flags !== 3'b100) $display("FAIL ovf_calc: result=%h flags=%b want 80000000/100", result, flags); else passed++;
    checks++; if (mem[5] !== 32'h8000_0000 || mem[7] !== 32'h4) $display("FAIL ovf_mem: mem5=%h mem7=%h want 80000000/4", mem[5], mem[7]); else passed++;
    mem[0] = 32'd9; mem[1] = 32'd9;
    run_job(1'b0, lat);
    checks++; if (result !== 32'h0 || flags !== 3'b010) $display("FAIL zero_calc: result=%h flags=%b want 0/010", result, flags); else passed++;
    checks++; if (mem[2] !== 32'h0 || mem[6] !== 32'h2) $display("FAIL zero_mem: mem2=%h mem6=%h want 0/2", mem[2], mem[6]); else passed++;
    mem[3] = 32'hFFFF_FFFF; mem[4] = 32'h1;
    run_job(1'b1, lat);
    checks++; if (result !== 32'h0 || flags !== 3'b011) $display("FAIL carry_calc: result=%h flags=%b want 0/011", result, flags); else passed++;
    checks++; if (mem[5] !== 32'h0 || mem[7] !== 32'h3) $display("FAIL carry_mem: mem5=%h mem7=%h want 0/3", mem[5], mem[7]); else passed++;
    checks++; if (job_cnt !== exp_cnt) $display("FAIL ovf_jobcnt: got %0d want %0d", job_cnt, exp_cnt); else passed++;
  endtask

  // start held high; op wiggles mid-job; a second job must start exactly at edge 11.
  task automatic test_back_to_back();
    int cyc;
    mem[0] = 32'd10; mem[1] = 32'd4; mem[2] = 32'd0;
    @(posedge clk); #1; start = 1'b1; op = 1'b0;
    @(posedge clk); #1; cyc = 1; op = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 5) op = 1'b0;
    end
    checks++; if (cyc !== 10) $display("FAIL b2b_latency1: done in cycle %0d want 10", cyc); else passed++;
    checks++; if (result !== 32'd6 || mem[2] !== 32'd6) $display("FAIL b2b_result1: result=%h mem2=%h want 6/6", result, mem[2]); else passed++;
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (job_cnt !== exp_cnt) $display("FAIL b2b_jobcnt1: got %0d want %0d", job_cnt, exp_cnt); else passed++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_gap: busy=%b done=%b want 0/0", busy, done); else passed++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_restart: busy=%b want 1", busy); else passed++;
    start = 1'b0; mem[2] = 32'd0; cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (cyc !== 10 || mem[2] !== 32'd6) $display("FAIL b2b_job2: cycle %0d mem2=%h want 10/6", cyc, mem[2]); else passed++;
    checks++; if (job_cnt !== exp_cnt) $display("FAIL b2b_jobcnt2: got %0d want %0d", job_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_wrap();
    int lat;
    mem[0] = 32'd1; mem[1] = 32'd1;
    for (int i = 0; i < 300 && exp_cnt != 8'd255; i++) run_job(1'b0, lat);
    checks++; if (job_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", job_cnt); else passed++;
    run_job(1'b0, lat);
    checks++; if (lat !== 10 || job_cnt !== 8'd0) $display("FAIL wrap_0: cycle %0d job_cnt=%0d want 10/0", lat, job_cnt); else passed++;
  endtask

  task automatic test_reset_midjob();
    int lat;
    mem[3] = 32'h100; mem[4] = 32'h23; mem[5] = 32'h0; mem[7] = 32'hABCD;
    @(posedge clk); #1; start = 1'b1; op = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (WE !== 1'b1 || DirRam !== 5'd5) $display("FAIL mid_pulse: WE=%b DirRam=%0d want 1/5", WE, DirRam); else passed++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done, WE} !== 3'b000) $display("FAIL mid_ctl: busy/done/WE=%b want 000", {busy, done, WE}); else passed++;
    checks++; if (DirRam !== 5'd0 || DatosE !== 32'd0 || result !== 32'd0 || flags !== 3'd0 || job_cnt !== 8'd0)
      $display("FAIL mid_regs: DirRam=%h DatosE=%h result=%h flags=%b job_cnt=%0d want 0", DirRam, DatosE, result, flags, job_cnt);
    else passed++;
    checks++; if (mem[5] !== 32'h123 || mem[7] !== 32'hABCD) $display("FAIL mid_mem: mem5=%h mem7=%h want 123/abcd", mem[5], mem[7]); else passed++;
    exp_cnt = 8'd0;
    @(posedge clk); #1; rst_n = 1'b1;
    checks++; if (done !== 1'b0 || job_cnt !== 8'd0) $display("FAIL mid_nodone: done=%b job_cnt=%0d want 0/0", done, job_cnt); else passed++;
    mem[5] = 32'h0;
    run_job(1'b1, lat);
    checks++; if (lat !== 10 || result !== 32'h123 || flags !== 3'b000) $display("FAIL mid_rerun: cycle %0d result=%h flags=%b want 10/123/000", lat, result, flags); else passed++;
    checks++; if (mem[5] !== 32'h123 || mem[7] !== 32'h0 || job_cnt !== 8'd1) $display("FAIL mid_rerun_mem: mem5=%h mem7=%h job_cnt=%0d want 123/0/1", mem[5], mem[7], job_cnt); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    test_reset();
    test_suma();
    test_resta_borrow();
    test_ovf_zero();
    test_back_to_back();
    test_wrap();
    test_reset_midjob();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hs_fail !== 0) $display("FAIL handshake_total: %0d violations want 0", hs_fail); else passed++;
    checks++; if (hs_seen < 2) $display("FAIL handshake_seen: %0d pulses checked want >=2", hs_seen); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
